// File: rtl/div_pkg.sv
// Shared types and constants for the divider mantissa/dividend shift datapath.
package div_pkg;

    localparam int unsigned DEF_WIDTH = 26;
    localparam int unsigned DEF_CNT_W = 5;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/div_shift_seq_if.sv
// Controller <-> shift-sequencer handshake and data bus.
interface div_shift_seq_if #(
    parameter int unsigned WIDTH = div_pkg::DEF_WIDTH,
    parameter int unsigned CNT_W = div_pkg::DEF_CNT_W
);
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             start;
    logic [CNT_W-1:0] shamt;
    logic             dir;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output ld, ld_val, start, shamt, dir, sin,
        input  q, sout, busy, done
    );

    modport slave (
        input  ld, ld_val, start, shamt, dir, sin,
        output q, sout, busy, done
    );
endinterface

// File: rtl/div_shift_core.sv
// Combinational one-step shifter: next register value and the bit that falls out.
// With KEEP_SIGN the MSB is frozen and WIDTH must be at least 3.
module div_shift_core
    import div_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned KEEP_SIGN = 1
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic             sin,
    output logic [WIDTH-1:0] q_nxt_c,
    output logic             sout_nxt_c
);

    generate
        if (KEEP_SIGN != 0) begin : g_keep_sign
            // Sign bit held; serial data enters at LSB (left) or just below the sign (right).
            always_comb begin
                q_nxt_c    = q;
                sout_nxt_c = 1'b0;
                if (dir == DIR_RIGHT) begin
                    q_nxt_c    = {q[WIDTH-1], sin, q[WIDTH-2:1]};
                    sout_nxt_c = q[0];
                end else begin
                    q_nxt_c    = {q[WIDTH-1], q[WIDTH-3:0], sin};
                    sout_nxt_c = q[WIDTH-2];
                end
            end
        end else begin : g_full
            // Whole register shifts; serial data enters at LSB (left) or MSB (right).
            always_comb begin
                q_nxt_c    = q;
                sout_nxt_c = 1'b0;
                if (dir == DIR_RIGHT) begin
                    q_nxt_c    = {sin, q[WIDTH-1:1]};
                    sout_nxt_c = q[0];
                end else begin
                    q_nxt_c    = {q[WIDTH-2:0], sin};
                    sout_nxt_c = q[WIDTH-1];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/div_shift_seq.sv
// Self-sequencing shift register: parallel load plus an automatic burst of N shifts
// with a start/busy/done handshake toward the divider controller.
module div_shift_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned KEEP_SIGN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    div_shift_seq_if.slave bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_r;
    logic [WIDTH-1:0] q_r;
    logic             sout_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] q_nxt_c;
    logic             sout_nxt_c;

    div_shift_core #(
        .WIDTH     (WIDTH),
        .KEEP_SIGN (KEEP_SIGN)
    ) u_core (
        .q          (q_r),
        .dir        (dir_r),
        .sin        (bus.sin),
        .q_nxt_c    (q_nxt_c),
        .sout_nxt_c (sout_nxt_c)
    );

    // Burst sequencer; load overrides everything and silently aborts a burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            dir_r  <= DIR_LEFT;
            q_r    <= '0;
            sout_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (bus.ld) begin
            q_r    <= bus.ld_val;
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        if (bus.shamt != '0) begin
                            dir_r  <= bus.dir;
                            cnt    <= bus.shamt;
                            busy_r <= 1'b1;
                            state  <= ST_SHIFT;
                        end else begin
                            // Empty burst: report completion without touching q.
                            done_r <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    q_r    <= q_nxt_c;
                    sout_r <= sout_nxt_c;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // start is ignored here; it is only seen again from IDLE.
                    done_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.q    = q_r;
    assign bus.sout = sout_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: doc/div_shift_seq.md
Name: div_shift_seq

Overview:
- Parametrised, self-sequencing shift register for the mantissa/dividend datapath of the IEEE-754 divider.
- Supports parallel load plus an automatic run of N serial shifts, left or right, with an optional protected sign bit.
- A start/busy/done handshake lets the division controller request a burst of shifts instead of toggling a shift enable cycle by cycle.
- Sits between the divider controller and the subtract/compare stage.

Parameters:
- WIDTH, 26, register width in bits (MSB = sign when KEEP_SIGN=1).
- CNT_W, 5, width of the shift-count request; max burst = 2^CNT_W - 1.
- KEEP_SIGN, 1, 1 = bit WIDTH-1 is never shifted; 0 = whole register shifts.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ld  in  1  parallel load strobe.
- ld_val  in  WIDTH  parallel load value.
- start  in  1  request a shift burst.
- shamt  in  CNT_W  number of shifts in the burst.
- dir  in  1  0 = left (serial in at LSB), 1 = right (serial in below the sign/MSB).
- sin  in  1  serial input bit, sampled on every shift edge.
- q  out  WIDTH  register contents.
- sout  out  1  last bit shifted out (registered).
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async, rst_n=0):
  - q=0, sout=0, busy=0, done=0, count=0, state=IDLE.
  - Reset asserted mid-burst aborts the burst immediately. No done pulse.
- States: IDLE, SHIFT, DONE. A registered dir_r is latched at start.
- Load:
  - ld=1 on any edge in any state: q<=ld_val, state<=IDLE, busy<=0, done<=0, sout unchanged.
  - ld has highest priority. It aborts a running burst, and no done is produced for the aborted burst.
- IDLE:
  - start=1, shamt>0: dir_r<=dir, count<=shamt, state<=SHIFT, busy<=1.
  - start=1, shamt=0: state<=DONE, q unchanged. Gives done one cycle after start, with no shift.
  - start=0: hold.
- SHIFT (each edge):
  - Perform one shift and set count<=count-1.
  - When count==1, state<=DONE and busy<=0 on that same edge.
- DONE:
  - done=1 for exactly one cycle, then state<=IDLE.
  - start is accepted again on the edge that leaves DONE only via IDLE. A start sampled while in DONE is ignored.
- Latency: start at edge E0 gives shifts on edges E1..En; busy high E0..En; done high between En and En+1.
- start while busy or in DONE is ignored. shamt and dir changes after acceptance have no effect. sin is used live on each shift edge.
- Left shift:
  - KEEP_SIGN=1: q<={q[W-1], q[W-3:0], sin}, sout<=q[W-2].
  - KEEP_SIGN=0: q<={q[W-2:0], sin}, sout<=q[W-1].
- Right shift:
  - KEEP_SIGN=1: q<={q[W-1], sin, q[W-2:1]}, sout<=q[0].
  - KEEP_SIGN=0: q<={sin, q[W-1:1]}, sout<=q[0].
- No wrap-around: bits shifted out are lost except the last one, which is held in sout.
- shamt >= WIDTH is legal; the register simply fills with sin values.

Decomposition:
- Shared package (div_pkg):
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - Default WIDTH=26 for the single-precision divider.
- One natural sub-module: div_shift_core, the combinational next-q/next-sout shifter selected by dir_r and KEEP_SIGN. The FSM and counter stay in the top module.

Test Plan:
- Reset/load: rst_n=0 mid-burst → q=0, busy=0, done=0 immediately, asynchronously. Release, then ld=1 with ld_val=26'h1000_03C → q=26'h1000_03C next edge.
- Left burst, KEEP_SIGN=1: q=26'h2000_001, start with shamt=4, dir=0, sin=1 → after 4 edges q=26'h200_001F, sign kept. busy for 4 cycles, done pulse on cycle 5, sout=0.
- Right burst, KEEP_SIGN=0: q=26'h000_000F, shamt=3, dir=1, sin=0 → q=26'h000_0001, sout=1, done one cycle after the third shift.
- Zero count: start with shamt=0 → q unchanged, busy never high, done=1 exactly one cycle after start.
- Abort and ignore: start shamt=10, then ld=1 at shift 3 with ld_val=26'h155 → q=26'h155, busy=0, no done pulse. A second start asserted while busy in another burst is ignored, and the burst length stays at the original shamt.
